// File: rtl/frac_lut_cfg_pkg.sv
// Shared constants and state encoding for the fractured LUT6 configuration loader.
package frac_lut_cfg_pkg;
  localparam int LUT_SIZE   = 6;
  localparam int SRAM_W     = 2**LUT_SIZE;
  localparam int MODE_W     = 2;
  localparam int FRAME_W    = SRAM_W + MODE_W + 1;
  localparam int CNT_W      = $clog2(FRAME_W);
  localparam int MODE_BASE  = SRAM_W;
  localparam int PARITY_IDX = SRAM_W + MODE_W;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, READ} state_t;
endpackage

// File: rtl/frac_lut_cfg_shadow.sv
// Shadow frame register: one indexed bit written per cycle, with clear and running parity.
module frac_lut_cfg_shadow
  import frac_lut_cfg_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic             d,
  output logic [0:W-1]     q,
  output logic             parity
);
  // Each index is written at most once per frame, so a toggle tracks XOR of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      q      <= '0;
      parity <= 1'b0;
    end else if (we) begin
      parity <= parity ^ d;
      for (int i = 0; i < W; i++)
        if (idx == CNT_W'(i)) q[i] <= d;
    end
  end
endmodule

// File: rtl/frac_lut6_cfg_loader.sv
// Serial config loader for the fractured LUT6: shadow load, parity check, atomic commit, readback.
module frac_lut6_cfg_loader
  import frac_lut_cfg_pkg::*;
#(
  parameter int PARITY_EN = 1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic              busy,
  input  logic              rb_start,
  input  logic              rb_ready,
  output logic              rb_valid,
  output logic              rb_bit,
  output logic [0:SRAM_W-1] sram,
  output logic [0:SRAM_W-1] sram_inv,
  output logic [0:MODE_W-1] mode,
  output logic [0:MODE_W-1] mode_inv
);
  localparam int FW = SRAM_W + MODE_W + PARITY_EN;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FW - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, rb_cnt, rb_cnt_nxt;
  logic             ld_acc, sh_clr, sh_par, perr, commit;
  logic [0:FW-1]    sh_q, act_frame;

  frac_lut_cfg_shadow #(.W(FW)) u_shadow (
    .clk    (prog_clk),
    .rst    (pReset),
    .clr    (sh_clr),
    .we     (ld_acc),
    .idx    (cnt),
    .d      (cfg_bit),
    .q      (sh_q),
    .parity (sh_par)
  );

  // Readback parity slot is recomputed from the active config, not stored.
  if (PARITY_EN != 0) begin : g_par
    assign act_frame = {sram, mode, ^{sram, mode}};
  end else begin : g_nopar
    assign act_frame = {sram, mode};
  end

  assign perr   = (PARITY_EN != 0) && sh_par;
  assign commit = (state == CHECK) && !perr;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rb_cnt_nxt = rb_cnt;
    ld_acc     = 1'b0;
    sh_clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          sh_clr    = 1'b1;
        end else if (rb_start) begin
          state_nxt  = READ;
          rb_cnt_nxt = '0;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_nxt = IDLE;
        end else if (cfg_valid && cfg_ready) begin
          ld_acc = 1'b1;
          if (cnt == LAST) state_nxt = CHECK;
          else             cnt_nxt   = cnt + 1'b1;
        end
      end
      CHECK: state_nxt = IDLE;
      READ: begin
        if (rb_valid && rb_ready) begin
          if (rb_cnt == LAST) state_nxt  = IDLE;
          else                rb_cnt_nxt = rb_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= IDLE;
      cnt       <= '0;
      rb_cnt    <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      rb_valid  <= 1'b0;
      rb_bit    <= 1'b0;
      sram      <= '0;
      sram_inv  <= '1;
      mode      <= '0;
      mode_inv  <= '1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rb_cnt    <= rb_cnt_nxt;
      cfg_ready <= (state_nxt == LOAD);
      busy      <= (state_nxt != IDLE);
      rb_valid  <= (state_nxt == READ);
      rb_bit    <= (state_nxt == READ) ? act_frame[rb_cnt_nxt] : 1'b0;
      cfg_done  <= commit;
      cfg_err   <= (state == CHECK) && perr;
      if (commit) begin
        sram     <= sh_q[0:SRAM_W-1];
        sram_inv <= ~sh_q[0:SRAM_W-1];
        mode     <= sh_q[MODE_BASE +: MODE_W];
        mode_inv <= ~sh_q[MODE_BASE +: MODE_W];
      end
    end
  end
endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Scoreboard bench for frac_lut6_cfg_loader: directed frames, abort, readback, reset cases.
module tb_frac_lut6_cfg_loader;
  logic        prog_clk = 0, pReset;
  logic        cfg_start, cfg_abort, cfg_valid, cfg_bit, rb_start, rb_ready;
  logic        cfg_ready, cfg_done, cfg_err, busy, rb_valid, rb_bit;
  logic [0:63] sram, sram_inv;
  logic [0:1]  mode, mode_inv;

  int total = 0, bad = 0;

  typedef struct {bit err; logic [0:63] s; logic [0:1] m;} cfg_exp_t;
  cfg_exp_t cfgq[$];
  bit       rbq[$];

  // Hand-computed: 0xAAAA.. has 32 ones, mode 01 one -> parity 1.
  //                0x0123456789ABCDEF has 32 ones, mode 10 one -> parity 1.
  localparam logic [0:63] A_S = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [0:63] B_S = 64'h0123_4567_89AB_CDEF;
  logic [0:66] fa, fa_bad, fb;

  frac_lut6_cfg_loader dut (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .busy(busy), .rb_start(rb_start), .rb_ready(rb_ready),
    .rb_valid(rb_valid), .rb_bit(rb_bit), .sram(sram), .sram_inv(sram_inv),
    .mode(mode), .mode_inv(mode_inv)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sram"}, sram, 64'h0);
    chk({tag, "_sram_inv"}, sram_inv, {64{1'b1}});
    chk({tag, "_mode"}, {62'h0, mode}, 64'h0);
    chk({tag, "_mode_inv"}, {62'h0, mode_inv}, 64'h3);
    chk({tag, "_ctl"}, {58'h0, cfg_ready, cfg_done, cfg_err, busy, rb_valid, rb_bit}, 64'h0);
  endtask

  // Monitor: every done/err pulse and every readback handshake pops the scoreboard.
  always @(negedge prog_clk) begin
    if (!pReset) begin
      if (cfg_done || cfg_err) begin
        if (cfgq.size() == 0) chk("unexpected_cfg_pulse", {cfg_done, cfg_err}, 64'h0);
        else begin
          cfg_exp_t e;
          e = cfgq.pop_front();
          chk("pulse_kind", {cfg_done, cfg_err}, e.err ? 64'h1 : 64'h2);
          chk("sram", sram, e.s);
          chk("sram_inv", sram_inv, ~e.s);
          chk("mode", {62'h0, mode}, {62'h0, e.m});
          chk("mode_inv", {62'h0, mode_inv}, {62'h0, ~e.m});
        end
      end
      if (rb_valid && rb_ready) begin
        if (rbq.size() == 0) chk("unexpected_rb_bit", 64'h1, 64'h0);
        else chk("rb_bit", {63'h0, rb_bit}, {63'h0, rbq.pop_front()});
      end
    end
  end

  // kind: 0 full frame, 1 abort at bit stop_at, 2 reset at bit stop_at
  task automatic send(input logic [0:66] f, input bit toggle, input int stop_at, input int kind);
    int i = 0, c = 0;
    @(posedge prog_clk); #1 cfg_start = 1;
    @(posedge prog_clk); #1 cfg_start = 0;
    while (i < 67) begin
      if (kind == 2 && i == stop_at) begin
        pReset = 1; cfg_valid = 0;
        #1 check_reset("rst_load");
        @(posedge prog_clk); #1 pReset = 0;
        return;
      end
      cfg_valid = toggle ? (c % 2 == 0) : 1'b1;
      cfg_bit   = f[i];
      cfg_abort = (kind == 1 && i == stop_at);
      @(posedge prog_clk); #1;
      c++;
      if (cfg_abort) begin
        cfg_abort = 0; cfg_valid = 0;
        return;
      end
      if (cfg_valid) i++;
    end
    cfg_valid = 0;
    chk("check_ready_low", {63'h0, cfg_ready}, 64'h0);
    @(posedge prog_clk); #1;
    chk("commit_latency", {63'h0, cfg_done | cfg_err}, 64'h1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge prog_clk); #1; n++;
    end
    chk("idle_timeout", {63'h0, busy}, 64'h0);
    repeat (2) @(posedge prog_clk);
    #1;
  endtask

  initial begin
    pReset = 1; cfg_start = 0; cfg_abort = 0; cfg_valid = 0; cfg_bit = 0;
    rb_start = 0; rb_ready = 0;
    fa = {A_S, 2'b01, 1'b1};
    fa_bad = {A_S, 2'b01, 1'b0};
    fb = {B_S, 2'b10, 1'b1};
    repeat (3) @(posedge prog_clk);
    #1 pReset = 0;
    @(negedge prog_clk) check_reset("post_reset");

    // good frame A
    cfgq.push_back('{1'b0, A_S, 2'b01});
    send(fa, 0, -1, 0);
    wait_idle(20);
    chk("a_sram_inv", sram_inv, 64'h5555_5555_5555_5555);
    chk("a_mode_inv", {62'h0, mode_inv}, 64'h2);

    // flipped parity: error, config keeps A
    cfgq.push_back('{1'b1, A_S, 2'b01});
    send(fa_bad, 0, -1, 0);
    wait_idle(20);

    // gapped valid then abort after bit 30: no pulse, A kept
    send(fb, 1, 31, 1);
    wait_idle(20);
    chk("abort_sram", sram, A_S);
    chk("abort_mode", {62'h0, mode}, 64'h1);

    // good frame B
    cfgq.push_back('{1'b0, B_S, 2'b10});
    send(fb, 0, -1, 0);
    wait_idle(20);

    // readback with random stalls
    for (int i = 0; i < 67; i++) rbq.push_back(fb[i]);
    @(posedge prog_clk); #1 rb_start = 1;
    @(posedge prog_clk); #1 rb_start = 0;
    for (int n = 0; n < 1000 && busy; n++) begin
      rb_ready = 1'($urandom_range(0, 1));
      @(posedge prog_clk); #1;
    end
    rb_ready = 0;
    chk("rb_done_busy", {63'h0, busy}, 64'h0);
    chk("rb_valid_drop", {63'h0, rb_valid}, 64'h0);
    chk("rb_all_bits", rbq.size(), 64'h0);

    // reset at bit 40 of a load
    send(fa, 0, 40, 2);
    @(negedge prog_clk) check_reset("after_rst_load");

    // reset during readback
    cfgq.push_back('{1'b0, B_S, 2'b10});
    send(fb, 0, -1, 0);
    wait_idle(20);
    rb_start = 1;
    @(posedge prog_clk); #1 rb_start = 0;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("rb_stall_valid", {63'h0, rb_valid}, 64'h1);
    chk("rb_first_bit", {63'h0, rb_bit}, {63'h0, fb[0]});
    pReset = 1;
    #1 check_reset("rst_read");
    @(posedge prog_clk); #1 pReset = 0;

    // simultaneous starts: load wins
    cfg_start = 1; rb_start = 1;
    @(posedge prog_clk); #1 cfg_start = 0; rb_start = 0;
    @(negedge prog_clk);
    chk("both_start", {61'h0, busy, cfg_ready, rb_valid}, 64'h6);
    @(posedge prog_clk); #1 cfg_abort = 1;
    @(posedge prog_clk); #1 cfg_abort = 0;
    wait_idle(20);
    chk("both_start_rb", {63'h0, rb_valid}, 64'h0);
    chk("both_start_sram", sram, 64'h0);

    chk("cfgq_empty", cfgq.size(), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
